// File: rtl/instr_read_sequencer.sv
// instr_read_sequencer: walks a window of instruction-register locations
// through read_pointer. It captures each returned word (opcode, operands,
// result) and presents it on a valid/ready stream.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   start, base_addr,    start a walk of `count` locations from base_addr;
//   count                start is sampled only in IDLE
//   abort                cancels the current walk, with no done pulse
//   read_pointer, iw_*   read address and combinational read data
//   out_valid/out_ready  output handshake
//   out_opc/_op_a/_op_b  captured word fields
//   out_res, out_addr    captured result and source location
//   out_last             final word of the walk
//   out_mismatch         recomputed result differs from out_res
//   busy, done           walk in progress; one-cycle completion pulse
//   err_cnt              saturating count of accepted mismatching words
//
// Optional feature macro: INSTR_RESULT_CHECK_EN. When it is defined, the
// expected result is recomputed and compared. When it is undefined,
// out_mismatch and err_cnt are tied to 0.
module instr_read_sequencer #(
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 4,
    parameter int OP_W   = 32,
    parameter int RES_W  = 64,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic [ADDR_W-1:0] read_pointer,
    input  logic [OPC_W-1:0]  iw_opc,
    input  logic [OP_W-1:0]   iw_op_a,
    input  logic [OP_W-1:0]   iw_op_b,
    input  logic [RES_W-1:0]  iw_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  out_opc,
    output logic [OP_W-1:0]   out_op_a,
    output logic [OP_W-1:0]   out_op_b,
    output logic [RES_W-1:0]  out_res,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              out_mismatch,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [ADDR_W:0] remaining;
    logic            go;
    logic            accept;

    // abort outranks start, and a handshake that coincides with abort
    // is not treated as accepted
    assign go     = start & ~abort;
    assign accept = (state == S_HOLD) & out_valid & out_ready & ~abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (go) state_nx = (count == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_nx = abort ? S_IDLE : S_HOLD;
            S_HOLD: begin
                if (abort)       state_nx = S_IDLE;
                else if (accept) state_nx = out_last ? S_DONE : S_FETCH;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_pointer <= '0;
            remaining    <= '0;
            out_valid    <= 1'b0;
            out_opc      <= '0;
            out_op_a     <= '0;
            out_op_b     <= '0;
            out_res      <= '0;
            out_addr     <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go && count != '0) begin
                        remaining    <= count;
                        read_pointer <= base_addr;
                        busy         <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else begin
                        out_opc   <= iw_opc;
                        out_op_a  <= iw_op_a;
                        out_op_b  <= iw_op_b;
                        out_res   <= iw_res;
                        out_addr  <= read_pointer;
                        out_last  <= (remaining == (ADDR_W+1)'(1));
                        out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (accept) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - 1'b1;
                        // wraps naturally modulo the register depth
                        if (!out_last)
                            read_pointer <= read_pointer + 1'b1;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    if (!abort) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_RESULT_CHECK_EN
    logic signed [RES_W-1:0] sa;
    logic signed [RES_W-1:0] sb;
    logic signed [RES_W-1:0] exp_res;

    always_comb begin
        sa      = {{(RES_W-OP_W){iw_op_a[OP_W-1]}}, iw_op_a};
        sb      = {{(RES_W-OP_W){iw_op_b[OP_W-1]}}, iw_op_b};
        exp_res = '0;
        case (iw_opc)
            OPC_W'(1): exp_res = sa;
            OPC_W'(2): exp_res = sb;
            OPC_W'(3): exp_res = sa + sb;
            OPC_W'(4): exp_res = sa - sb;
            OPC_W'(5): exp_res = sa * sb;
            OPC_W'(6): if (sb != '0) exp_res = sa / sb;
            OPC_W'(7): if (sb != '0) exp_res = sa % sb;
            default:   exp_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_mismatch <= 1'b0;
            err_cnt      <= '0;
        end else begin
            if (state == S_FETCH && !abort)
                out_mismatch <= (exp_res != iw_res);
            if (accept && out_mismatch && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign out_mismatch = 1'b0;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_instr_read_sequencer.sv
// Bench for instr_read_sequencer: a transaction-level model predicts the
// word stream, done and busy, and these are compared every cycle.
module tb_instr_read_sequencer;

    localparam int AW = 5;
    localparam int OW = 4;
    localparam int PW = 32;
    localparam int RW = 64;
    localparam int EW = 16;
`ifdef INSTR_RESULT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          abort;
    logic [AW-1:0] read_pointer;
    logic [OW-1:0] iw_opc;
    logic [PW-1:0] iw_op_a;
    logic [PW-1:0] iw_op_b;
    logic [RW-1:0] iw_res;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_opc;
    logic [PW-1:0] out_op_a;
    logic [PW-1:0] out_op_b;
    logic [RW-1:0] out_res;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          out_mismatch;
    logic          busy;
    logic          done;
    logic [EW-1:0] err_cnt;

    logic [OW-1:0] mem_opc [32];
    logic [PW-1:0] mem_a   [32];
    logic [PW-1:0] mem_b   [32];
    logic [RW-1:0] mem_res [32];

    assign iw_opc  = mem_opc[read_pointer];
    assign iw_op_a = mem_a[read_pointer];
    assign iw_op_b = mem_b[read_pointer];
    assign iw_res  = mem_res[read_pointer];

    instr_read_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .count(count), .abort(abort),
        .read_pointer(read_pointer),
        .iw_opc(iw_opc), .iw_op_a(iw_op_a),
        .iw_op_b(iw_op_b), .iw_res(iw_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opc(out_opc), .out_op_a(out_op_a),
        .out_op_b(out_op_b), .out_res(out_res),
        .out_addr(out_addr), .out_last(out_last),
        .out_mismatch(out_mismatch), .busy(busy),
        .done(done), .err_cnt(err_cnt)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            4'd1: return sa;
            4'd2: return sb;
            4'd3: return sa + sb;
            4'd4: return sa - sb;
            4'd5: return sa * sb;
            4'd6: return (sb == 0) ? 64'd0 : sa / sb;
            4'd7: return (sb == 0) ? 64'd0 : sa % sb;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return $urandom;
            default: return 32'($urandom_range(0, 20)) - 32'd10;
        endcase
    endfunction

    task automatic set_word(input int i, input logic [3:0] o,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] r);
        mem_opc[i] = o;
        mem_a[i]   = a;
        mem_b[i]   = b;
        mem_res[i] = r;
    endtask

    task automatic rand_word(input int i);
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        o = 4'($urandom_range(0, 9));
        a = rand_op();
        b = rand_op();
        if ($urandom_range(0, 1) == 1) set_word(i, o, a, b, ref_result(o, a, b));
        else set_word(i, o, a, b, {$urandom, $urandom});
    endtask

    // ---- transaction model ----
    typedef struct {
        logic [AW-1:0] addr;
        logic [OW-1:0] opc;
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic [RW-1:0] res;
        logic          mm;
    } exp_t;

    exp_t q[$];
    bit   m_active = 0;
    bit   m_valid  = 0;
    bit   m_busy   = 0;
    bit   m_done   = 0;
    bit   fetch_pend = 0;
    bit   done_pend  = 0;
    int   m_err = 0;

    int ncyc = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    int done_cyc = -1;
    int last_hs_cyc = -1;
    int first_valid_cyc = -1;
    logic [AW-1:0] hs_addr[$];
    logic          hs_last[$];
    logic          hs_mm[$];
    logic [RW-1:0] hs_res[$];

    task automatic clear_logs();
        hs_addr.delete();
        hs_last.delete();
        hs_mm.delete();
        hs_res.delete();
        first_valid_cyc = -1;
    endtask

    always @(negedge clk) begin
        bit was_active;
        exp_t e;
        ncyc++;
        if (reset) begin
            q.delete();
            m_active = 0; m_valid = 0; m_busy = 0; m_done = 0;
            fetch_pend = 0; done_pend = 0; m_err = 0;
        end else begin
            chk("out_valid", out_valid, m_valid);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("err_cnt", err_cnt, m_err);
            if (done) begin done_cnt++; done_cyc = ncyc; end
            if (out_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = ncyc;
            end
            if (out_valid && m_valid && q.size() > 0) begin
                chk("out_addr", out_addr, q[0].addr);
                chk("read_pointer", read_pointer, q[0].addr);
                chk("out_opc", out_opc, q[0].opc);
                chk("out_op_a", out_op_a, q[0].a);
                chk("out_op_b", out_op_b, q[0].b);
                chk("out_res", out_res, q[0].res);
                chk("out_last", out_last, q.size() == 1);
                chk("out_mismatch", out_mismatch, q[0].mm);
            end
            // predict the effect of the coming rising edge
            was_active = m_active;
            m_done = 0;
            if (abort) begin
                if (was_active) begin
                    q.delete();
                    m_active = 0; m_valid = 0; m_busy = 0;
                    fetch_pend = 0; done_pend = 0;
                end
            end else begin
                if (done_pend) begin
                    done_pend = 0; m_done = 1; m_busy = 0; m_active = 0;
                end
                if (fetch_pend) begin
                    fetch_pend = 0;
                    m_valid = 1;
                end else if (m_valid && out_ready) begin
                    hs_addr.push_back(out_addr);
                    hs_last.push_back(out_last);
                    hs_mm.push_back(out_mismatch);
                    hs_res.push_back(out_res);
                    last_hs_cyc = ncyc;
                    if (q[0].mm && m_err < 65535) m_err++;
                    void'(q.pop_front());
                    m_valid = 0;
                    if (q.size() == 0) done_pend = 1;
                    else fetch_pend = 1;
                end
                if (!was_active && start) begin
                    m_active = 1;
                    if (count == 0) begin
                        done_pend = 1;
                    end else begin
                        for (int i = 0; i < int'(count); i++) begin
                            e.addr = AW'((int'(base_addr) + i) % 32);
                            e.opc  = mem_opc[e.addr];
                            e.a    = mem_a[e.addr];
                            e.b    = mem_b[e.addr];
                            e.res  = mem_res[e.addr];
                            e.mm   = CHK_EN &&
                                (ref_result(e.opc, e.a, e.b) != e.res);
                            q.push_back(e);
                        end
                        fetch_pend = 1;
                        m_busy = 1;
                    end
                end
            end
        end
    end

    // ---- stimulus ----
    task automatic pulse_start(input logic [AW-1:0] b, input int c,
                               output int sn);
        @(posedge clk); #1;
        base_addr = b;
        count = (AW+1)'(c);
        start = 1;
        sn = ncyc;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_idle();
        bit ok;
        for (int k = 0; k < 400; k++) begin
            if (!m_active) break;
            @(posedge clk); #1;
        end
        ok = !m_active;
        chk("walk_end", ok, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        bit ok;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            @(posedge clk); #1;
        end
        ok = out_valid;
        chk("wait_valid", ok, 1);
    endtask

    initial begin
        int sn;
        int dsnap;
        int vsnap;
        bit ok;
        reset = 1; start = 0; abort = 0; out_ready = 0;
        base_addr = '0; count = '0;
        for (int i = 0; i < 32; i++) rand_word(i);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_rp", read_pointer, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_res", out_res, 0);
        chk("rst_last", out_last, 0);
        reset = 0;

        // three-word walk from 0
        set_word(0, 4'd3, 32'd5, 32'd3, 64'd8);
        set_word(1, 4'd4, 32'd4, 32'd9, -64'sd5);
        set_word(2, 4'd2, 32'd7, 32'd2, 64'd2);
        out_ready = 1;
        clear_logs();
        pulse_start(0, 3, sn);
        wait_idle();
        chk("t1_n", hs_addr.size(), 3);
        if (hs_addr.size() == 3) begin
            chk("t1_a0", hs_addr[0], 0);
            chk("t1_a1", hs_addr[1], 1);
            chk("t1_a2", hs_addr[2], 2);
            chk("t1_l0", hs_last[0], 0);
            chk("t1_l2", hs_last[2], 1);
            chk("t1_m", {hs_mm[0], hs_mm[1], hs_mm[2]}, 0);
            chk("t1_r1", hs_res[1], 64'hFFFF_FFFF_FFFF_FFFB);
        end
        chk("t1_lat", first_valid_cyc - sn, 3);
        chk("t1_done", done_cyc - last_hs_cyc, 2);

        // wrap around the top of the register
        clear_logs();
        pulse_start(30, 4, sn);
        wait_idle();
        chk("t2_n", hs_addr.size(), 4);
        if (hs_addr.size() == 4) begin
            chk("t2_a0", hs_addr[0], 30);
            chk("t2_a1", hs_addr[1], 31);
            chk("t2_a2", hs_addr[2], 0);
            chk("t2_a3", hs_addr[3], 1);
        end

        // empty walk
        vsnap = valid_cnt;
        dsnap = done_cnt;
        pulse_start(5, 0, sn);
        wait_idle();
        chk("t3_done_at", done_cyc - sn, 3);
        chk("t3_ndone", done_cnt - dsnap, 1);
        chk("t3_novalid", valid_cnt - vsnap, 0);

        // stall in HOLD
        out_ready = 0;
        pulse_start(7, 2, sn);
        wait_valid();
        repeat (5) @(posedge clk);
        #1;
        chk("t4_valid", out_valid, 1);
        chk("t4_addr", out_addr, 7);
        chk("t4_rp", read_pointer, 7);
        out_ready = 1;
        wait_idle();

        // result check, then abort during a fetch
        set_word(10, 4'd6, 32'd7, 32'd0, 64'd0);
        set_word(11, 4'd5, -32'sd3, 32'd4, 64'd12);
        set_word(12, 4'd3, 32'd1, 32'd1, 64'd2);
        clear_logs();
        dsnap = done_cnt;
        pulse_start(10, 3, sn);
        for (int k = 0; k < 40; k++) begin
            if (hs_addr.size() >= 2) break;
            @(posedge clk); #1;
        end
        ok = hs_addr.size() >= 2;
        chk("t5_two", ok, 1);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        repeat (3) @(posedge clk);
        #1;
        if (hs_mm.size() >= 2) begin
            chk("t5_mm0", hs_mm[0], 0);
            chk("t5_mm1", hs_mm[1], CHK_EN);
        end
        chk("t5_err", err_cnt, CHK_EN ? 1 : 0);
        chk("t5_nodone", done_cnt - dsnap, 0);
        chk("t5_busy", busy, 0);

        // asynchronous reset while holding a word
        out_ready = 0;
        pulse_start(3, 2, sn);
        wait_valid();
        @(posedge clk);
        #2;
        reset = 1;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_rp", read_pointer, 0);
        @(posedge clk); #1;
        reset = 0;
        dsnap = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_nodone", done_cnt - dsnap, 0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 40) == 0);
            start = ($urandom_range(0, 5) == 0);
            base_addr = AW'($urandom);
            count = ($urandom_range(0, 7) == 0) ? 6'd32
                                               : 6'($urandom_range(0, 32));
            if (!m_active)
                for (int j = 0; j < 4; j++) rand_word($urandom_range(0, 31));
        end
        @(posedge clk); #1;
        start = 0;
        abort = 0;
        out_ready = 1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
